// File: rtl/game_sequencer_if.sv
// Button/collision inputs and game-flow outputs between the sequencer and its surroundings.
interface game_sequencer_if;
  logic        btn_flap;
  logic        btn_pause;
  logic        fail_in;
  logic [15:0] score_in;
  logic        tick;
  logic        flap_pulse;
  logic        dp_reset;
  logic [2:0]  state;
  logic [7:0]  countdown;
  logic [15:0] hiscore;
  logic        new_record;

  modport master (
    input  btn_flap, btn_pause, fail_in, score_in,
    output tick, flap_pulse, dp_reset, state, countdown, hiscore, new_record
  );

  modport slave (
    output btn_flap, btn_pause, fail_in, score_in,
    input  tick, flap_pulse, dp_reset, state, countdown, hiscore, new_record
  );
endinterface

// File: rtl/game_sequencer.sv
// Game-flow controller: tick divider, game state machine, tick-aligned flap requests
// and session high score for the flappy-bird datapath.
module game_sequencer #(
  parameter int unsigned TICK_DIV        = 5000000,
  parameter int unsigned COUNTDOWN_TICKS = 30,
  parameter int unsigned DEATH_TICKS     = 10
) (
  input logic               clk,
  input logic               rst,
  game_sequencer_if.master  bus
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);
  localparam int unsigned CNT_W = 8;
  localparam int unsigned SCR_W = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_PAUSE     = 3'd3,
    S_DYING     = 3'd4,
    S_OVER      = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               flap_hist_q, pause_hist_q;
  logic               flap_pend_q, flap_pend_d;
  logic               tick_q, tick_d;
  logic               flap_pulse_q, flap_pulse_d;
  logic               dp_reset_q, dp_reset_d;
  logic [CNT_W-1:0]   countdown_q, countdown_d;
  logic [CNT_W-1:0]   death_q, death_d;
  logic [SCR_W-1:0]   hiscore_q, hiscore_d;
  logic               new_record_q, new_record_d;

  logic base, flap_rise, pause_rise;

  assign base       = (div_cnt_q == DIV_W'(TICK_DIV - 1));
  assign flap_rise  = bus.btn_flap  & ~flap_hist_q;
  assign pause_rise = bus.btn_pause & ~pause_hist_q;
  assign div_cnt_d  = base ? '0 : div_cnt_q + DIV_W'(1);

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    flap_pend_d  = flap_pend_q;
    tick_d       = 1'b0;
    flap_pulse_d = 1'b0;
    countdown_d  = countdown_q;
    death_d      = death_q;
    hiscore_d    = hiscore_q;
    new_record_d = new_record_q;

    unique case (state_q)
      S_IDLE: begin
        if (flap_rise) begin
          state_d      = S_COUNTDOWN;
          countdown_d  = CNT_W'(COUNTDOWN_TICKS);
          new_record_d = 1'b0;
        end
      end
      S_COUNTDOWN: begin
        if (base) begin
          if (countdown_q == CNT_W'(1)) begin
            state_d     = S_PLAY;
            countdown_d = '0;
          end else begin
            countdown_d = countdown_q - CNT_W'(1);
          end
        end
      end
      S_PLAY: begin
        if (bus.fail_in) begin
          state_d = S_DYING;
          death_d = CNT_W'(DEATH_TICKS);
        end else if (pause_rise) begin
          state_d = S_PAUSE;
        end else if (base) begin
          // a rise on the clearing cycle re-arms the request for the next tick
          tick_d       = 1'b1;
          flap_pulse_d = flap_pend_q;
          flap_pend_d  = flap_rise;
        end else if (flap_rise) begin
          flap_pend_d = 1'b1;
        end
      end
      S_PAUSE: begin
        if (pause_rise) state_d = S_PLAY;
      end
      S_DYING: begin
        if (base) begin
          if (death_q == CNT_W'(1)) begin
            state_d = S_OVER;
            if (bus.score_in > hiscore_q) begin
              hiscore_d    = bus.score_in;
              new_record_d = 1'b1;
            end else begin
              new_record_d = 1'b0;
            end
          end else begin
            death_d = death_q - CNT_W'(1);
            tick_d  = 1'b1;
          end
        end
      end
      S_OVER: begin
        if (flap_rise) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) flap_pend_d = 1'b0;
    dp_reset_d = (state_d == S_IDLE) || (state_d == S_COUNTDOWN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      div_cnt_q    <= '0;
      flap_hist_q  <= 1'b0;
      pause_hist_q <= 1'b0;
      flap_pend_q  <= 1'b0;
      tick_q       <= 1'b0;
      flap_pulse_q <= 1'b0;
      dp_reset_q   <= 1'b1;
      countdown_q  <= '0;
      death_q      <= '0;
      hiscore_q    <= '0;
      new_record_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      flap_hist_q  <= bus.btn_flap;
      pause_hist_q <= bus.btn_pause;
      flap_pend_q  <= flap_pend_d;
      tick_q       <= tick_d;
      flap_pulse_q <= flap_pulse_d;
      dp_reset_q   <= dp_reset_d;
      countdown_q  <= countdown_d;
      death_q      <= death_d;
      hiscore_q    <= hiscore_d;
      new_record_q <= new_record_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.tick       = tick_q;
  assign bus.flap_pulse = flap_pulse_q;
  assign bus.dp_reset   = dp_reset_q;
  assign bus.countdown  = countdown_q;
  assign bus.hiscore    = hiscore_q;
  assign bus.new_record = new_record_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: a behavioural model predicts every cycle's outputs.
module tb_game_sequencer;

  localparam int unsigned TICK_DIV        = 4;
  localparam int unsigned COUNTDOWN_TICKS = 3;
  localparam int unsigned DEATH_TICKS     = 2;

  typedef struct packed {
    logic [2:0]  st;
    logic        tick;
    logic        fp;
    logic        dpr;
    logic [7:0]  cd;
    logic [15:0] hi;
    logic        nr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        f, p, fl;
  logic [15:0] sc;

  int n_cmp = 0;
  int n_err = 0;
  exp_t exp_q[$];

  // model state
  int          m_st, m_div, m_cd, m_death;
  bit          m_fh, m_ph, m_pend, m_tick, m_fp, m_dpr, m_nr;
  logic [15:0] m_hi;

  game_sequencer_if bus ();

  game_sequencer #(
    .TICK_DIV       (TICK_DIV),
    .COUNTDOWN_TICKS(COUNTDOWN_TICKS),
    .DEATH_TICKS    (DEATH_TICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  assign bus.btn_flap  = f;
  assign bus.btn_pause = p;
  assign bus.fail_in   = fl;
  assign bus.score_in  = sc;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the reference behaviour, using the currently driven inputs
  task automatic model_step();
    bit base, fr, pr;
    int nxt;
    base = (m_div == TICK_DIV - 1);
    fr   = f & !m_fh;
    pr   = p & !m_ph;
    if (rst) begin
      m_st = 0; m_div = 0; m_cd = 0; m_death = 0; m_fh = 0; m_ph = 0;
      m_pend = 0; m_tick = 0; m_fp = 0; m_dpr = 1; m_nr = 0; m_hi = '0;
      return;
    end
    m_tick = 0;
    m_fp   = 0;
    nxt    = m_st;
    case (m_st)
      0: if (fr) begin nxt = 1; m_cd = COUNTDOWN_TICKS; m_nr = 0; end
      1: if (base) begin
           if (m_cd == 1) begin nxt = 2; m_cd = 0; end
           else m_cd = m_cd - 1;
         end
      2: begin
           if (fl) begin nxt = 4; m_death = DEATH_TICKS; end
           else if (pr) nxt = 3;
           else if (base) begin m_tick = 1; m_fp = m_pend; m_pend = fr; end
           else if (fr) m_pend = 1;
         end
      3: if (pr) nxt = 2;
      4: if (base) begin
           if (m_death == 1) begin
             nxt  = 5;
             m_nr = (sc > m_hi);
             if (sc > m_hi) m_hi = sc;
           end else begin
             m_death = m_death - 1;
             m_tick  = 1;
           end
         end
      5: if (fr) nxt = 0;
      default: nxt = 0;
    endcase
    if (nxt != m_st) m_pend = 0;
    m_st  = nxt;
    m_dpr = (m_st <= 1);
    m_div = base ? 0 : m_div + 1;
    m_fh  = f;
    m_ph  = p;
  endtask

  // Drive current inputs for one cycle; expectation queued now, compared after the edge
  task automatic cyc();
    exp_t e, g;
    model_step();
    e.st = 3'(m_st); e.tick = m_tick; e.fp = m_fp; e.dpr = m_dpr;
    e.cd = 8'(m_cd); e.hi = m_hi; e.nr = m_nr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    check("state",      32'(bus.state),      32'(g.st));
    check("tick",       32'(bus.tick),       32'(g.tick));
    check("flap_pulse", 32'(bus.flap_pulse), 32'(g.fp));
    check("dp_reset",   32'(bus.dp_reset),   32'(g.dpr));
    check("countdown",  32'(bus.countdown),  32'(g.cd));
    check("hiscore",    32'(bus.hiscore),    32'(g.hi));
    check("new_record", 32'(bus.new_record), 32'(g.nr));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_state(input int s, input int budget);
    int k = 0;
    while (m_st != s && k < budget) begin cyc(); k++; end
    if (m_st != s) check("wait_state_timeout", 32'(m_st), 32'(s));
  endtask

  // Run until the divider model sits at v, so the next driven cycle has div_cnt==v
  task automatic run_until_div(input int v);
    int k = 0;
    while (m_div != v && k < 2 * TICK_DIV) begin cyc(); k++; end
    if (m_div != v) check("wait_div_timeout", 32'(m_div), 32'(v));
  endtask

  task automatic press_flap();
    f = 1'b1; cyc();
    f = 1'b0; cyc();
  endtask

  initial begin
    rst = 1'b1; f = 1'b0; p = 1'b0; fl = 1'b0; sc = 16'd0;
    run(2);
    rst = 1'b0;
    run(20);
    check("idle_state", 32'(bus.state), 32'd0);
    check("idle_dp_reset", 32'(bus.dp_reset), 32'd1);

    // game 1: countdown into play
    press_flap();
    wait_state(2, 40);
    run(10);

    // flap between ticks, then a second rise on the clearing cycle
    run_until_div(1);
    press_flap();
    run_until_div(TICK_DIV - 1);
    f = 1'b1; cyc();
    f = 1'b0; run(8);

    // pause with fail held, then resume
    p = 1'b1; cyc();
    p = 1'b0; fl = 1'b1; run(12);
    fl = 1'b0; cyc();
    p = 1'b1; cyc();
    p = 1'b0; run(10);

    // fail on a base cycle, dying, over with new record
    run_until_div(TICK_DIV - 1);
    fl = 1'b1; cyc();
    fl = 1'b0; sc = 16'd7;
    wait_state(5, 40);
    run(3);
    check("g1_hiscore", 32'(bus.hiscore), 32'd7);
    check("g1_new_record", 32'(bus.new_record), 32'd1);

    // game 2: equal score is no record
    press_flap();
    run(2);
    press_flap();
    wait_state(2, 40);
    run(6);
    fl = 1'b1; p = 1'b1; f = 1'b1; cyc();
    fl = 1'b0; p = 1'b0; f = 1'b0;
    wait_state(5, 40);
    run(3);
    check("g2_hiscore", 32'(bus.hiscore), 32'd7);
    check("g2_new_record", 32'(bus.new_record), 32'd0);

    // game 3: reset in the middle of dying, then countdown from a fresh divider
    press_flap();
    run(2);
    press_flap();
    wait_state(2, 40);
    run(5);
    fl = 1'b1; cyc();
    fl = 1'b0; cyc();
    rst = 1'b1; cyc();
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_hiscore", 32'(bus.hiscore), 32'd0);
    rst = 1'b0;
    press_flap();
    run(16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game-flow controller for the flappy-bird datapath.
- Generates the game tick, owns the game state machine (idle, countdown, play, pause, dying, over), holds the datapath in reset between games and delivers tick-aligned flap requests.
- Tracks the session high score.
- Sits between the debounced buttons and the bird/pipe/coin control datapath, which advances one step per tick.

Parameters:
- TICK_DIV, 5000000, clk cycles per game tick (100 ms at 50 MHz); must be >= 2.
- COUNTDOWN_TICKS, 30, number of ticks spent in COUNTDOWN (1..255).
- DEATH_TICKS, 10, number of ticks spent in DYING (1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_flap  in  1  debounced flap/start button (level)
- btn_pause  in  1  debounced pause button (level)
- fail_in  in  1  collision flag from datapath (level)
- score_in  in  16  current score from datapath, unsigned
- tick  out  1  one-clk game-step strobe to datapath
- flap_pulse  out  1  flap request; only ever high together with tick
- dp_reset  out  1  datapath re-initialise, level
- state  out  3  IDLE=0, COUNTDOWN=1, PLAY=2, PAUSE=3, DYING=4, OVER=5
- countdown  out  8  remaining countdown ticks; 0 outside COUNTDOWN
- hiscore  out  16  best score this session
- new_record  out  1  last finished game set a new hiscore

Behaviour:
- Reset (rst=1 at a clk edge, any state, mid-game included) puts everything to its reset value in that one cycle:
  - state=IDLE, tick=0, flap_pulse=0, dp_reset=1, countdown=0, hiscore=0, new_record=0.
  - Divider counter=0, flap_pend=0, button history registers=0.
- Divider: div_cnt counts 0..TICK_DIV-1, wraps to 0, and runs in every state.
  - base = (div_cnt==TICK_DIV-1).
  - The first base after reset occurs in cycle TICK_DIV-1.
- Edge detect: flap_rise = btn_flap & ~btn_flap_q, and likewise pause_rise. The history registers are sampled every cycle.
- Outputs tick, flap_pulse, dp_reset, countdown and new_record are registered. tick and flap_pulse rise in the cycle after the cycle in which base=1 and the state qualifies.
- tick qualifies when state is PLAY or DYING and no transition out of that state fires in the same cycle.
- flap_pend:
  - Set by flap_rise in PLAY only.
  - On a qualifying base in PLAY: flap_pulse=1 and flap_pend clears.
  - If flap_rise and a clear coincide, flap_pend stays 1.
  - Cleared on every state change.
  - flap_pulse is always 0 in DYING.
- dp_reset is 1 in IDLE and COUNTDOWN, and 0 in PLAY, PAUSE, DYING and OVER, so the frozen scene stays visible in OVER.
- State transitions (priority is top to bottom within a state):
  - IDLE:
    - flap_rise -> COUNTDOWN; countdown<=COUNTDOWN_TICKS; new_record<=0.
  - COUNTDOWN:
    - On base: countdown decrements.
    - On base with countdown==1 -> PLAY; countdown<=0.
    - Buttons are ignored.
  - PLAY:
    - fail_in=1 -> DYING; death counter<=DEATH_TICKS; no tick issued for that cycle even if base=1.
    - Otherwise pause_rise -> PAUSE.
    - Otherwise issue ticks as above.
  - PAUSE:
    - No ticks issued; the divider keeps running.
    - pause_rise -> PLAY.
    - fail_in and flap are ignored.
  - DYING:
    - Ticks continue so the bird falls.
    - On each base the death counter decrements.
    - On base with the death counter==1 -> OVER, with no tick issued for that base.
    - On the same edge: if score_in > hiscore (unsigned), hiscore<=score_in and new_record<=1, else new_record<=0. An equal score is not a record.
  - OVER:
    - flap_rise -> IDLE.
    - hiscore and new_record hold.
- The hiscore is cleared only by rst.
- Simultaneous events:
  - flap_rise in the same cycle as a PLAY->DYING transition is dropped.
  - pause_rise coinciding with fail_in in PLAY: fail wins.

Test Plan:
- Reset release with TICK_DIV=4, COUNTDOWN_TICKS=3 → state=0, dp_reset=1, tick never high over 20 cycles.
- btn_flap rise in IDLE → COUNTDOWN, countdown=3 then 2, 1 on successive bases; → PLAY on the third base; dp_reset falls with the PLAY entry; tick pulses every 4 cycles, 1 cycle wide.
- Flap in PLAY between ticks → flap_pulse=1 only with the next tick; a second rise landing on the clearing cycle → flap_pulse also on the following tick.
- pause_rise in PLAY → no ticks for 12 cycles; second pause_rise → ticks resume at the next base; fail_in held high during PAUSE has no effect.
- fail_in=1 in PLAY on a base cycle → no tick, state=4; with DEATH_TICKS=2 ticks continue with flap_pulse=0; after 2 bases state=5 and score_in=7 with hiscore=0 → hiscore=7, new_record=1. A second game ending with score_in=7 → hiscore=7, new_record=0.
- rst=1 in DYING with hiscore=7 → next cycle state=0, hiscore=0, dp_reset=1, div_cnt restarts (first base at cycle 3 after reset release).
